key_op_sequencer: RTL

KEY_OP_SEQUENCER -- requirements
Module: key_op_sequencer

---
 rtl/key_op_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/key_op_sequencer.sv
// -----------------------------------------------------------------------------
// key_op_sequencer
//
// Sequences keypad events into load/clear strobes for a two-operand
// add/subtract calculator. Key events are buffered in a small queue and
// consumed one at a time while the controller is in an entry state
// (ENTA, ENTB, RES). The load/clear/settle states are "busy" and never
// consume events.
//
// Typical flow:
//   ENTA --op--> LDA --> ENTB --equals--> LDB --> SETTLE --> LDR --> RES
//   RES --digit--> ENTA, and a clear key from any entry state goes to CLR.
//
// Parameters
//   FIFO_DEPTH  key-event queue depth (power of two, >= 2)
//   SETTLE_CYC  idle cycles between the load_b_n and load_r_n pulses (1..7)
//   OVF_BIT     index of the overflow bit within flags
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-high reset
//   key_valid  one-cycle key event pulse from the input unit
//   key_val    key code: 0-9 digit, A add, B sub, C clear, E equals
//   key_ready  queue can accept an event (combinational)
//   flags      arithmetic-unit flags, sampled during the load_r_n pulse
//   load_a_n   active-low one-cycle load strobe, operand A
//   load_b_n   active-low one-cycle load strobe, operand B
//   load_r_n   active-low one-cycle load strobe, result
//   add_sub    operation select: 0 add, 1 subtract
//   clear_iu   one-cycle clear strobe to the input unit
//   clear_au   one-cycle clear strobe to the arithmetic unit
//   disp_sel   display source: 0 keypad entry, 1 result
//   busy       high in any strobe or settle state
//   err        latched overflow of the last result
//   state      current state encoding (debug only)
// -----------------------------------------------------------------------------
module key_op_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE_CYC = 2,
    parameter int OVF_BIT    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_val,
    output logic       key_ready,
    input  logic [3:0] flags,
    output logic       load_a_n,
    output logic       load_b_n,
    output logic       load_r_n,
    output logic       add_sub,
    output logic       clear_iu,
    output logic       clear_au,
    output logic       disp_sel,
    output logic       busy,
    output logic       err,
    output logic [2:0] state
);

    // -------------------------------------------------------------------------
    // Local parameters and types
    // -------------------------------------------------------------------------
    localparam int PW  = $clog2(FIFO_DEPTH);        // queue pointer width
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;    // queue occupancy width
    localparam int SCW = $clog2(SETTLE_CYC + 1);    // settle counter width

    localparam logic [CW-1:0]  DEPTH_C     = CW'(FIFO_DEPTH);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        ST_ENTA   = 3'd0,
        ST_LDA    = 3'd1,
        ST_ENTB   = 3'd2,
        ST_LDB    = 3'd3,
        ST_SETTLE = 3'd4,
        ST_LDR    = 3'd5,
        ST_RES    = 3'd6,
        ST_CLR    = 3'd7
    } state_t;

    // -------------------------------------------------------------------------
    // Key-event queue
    // -------------------------------------------------------------------------
    logic [3:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [3:0]    head_key;

    // key_ready depends on occupancy only, so a full queue refuses a push
    // even in a cycle where an event is being popped.
    assign key_ready  = (fifo_cnt < DEPTH_C);
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = key_valid & key_ready;
    assign head_key   = fifo_mem[rd_ptr];

    // NOTE: the storage array has no reset; occupancy and pointers are reset,
    // so stale entries can never be read, and a resettable array would cost
    // a flop-based memory for nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= key_val;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Head-of-queue key decode
    // -------------------------------------------------------------------------
    logic is_digit;
    logic is_op;
    logic is_sub;
    logic is_clear;
    logic is_equals;

    assign is_digit  = (head_key <= 4'h9);
    assign is_sub    = (head_key == 4'hB);
    assign is_op     = (head_key == 4'hA) | is_sub;
    assign is_clear  = (head_key == 4'hC);
    assign is_equals = (head_key == 4'hE);

    // Only the overflow bit matters to the sequencer.
    logic flags_unused;
    assign flags_unused = ^flags;

    // -------------------------------------------------------------------------
    // Controller
    // -------------------------------------------------------------------------
    state_t         cur_state;
    state_t         next_state;
    logic           dig_seen;
    logic           dig_seen_nxt;
    logic           add_sub_nxt;
    logic           disp_sel_nxt;
    logic           err_nxt;
    logic [SCW-1:0] settle_cnt;
    logic [SCW-1:0] settle_cnt_nxt;
    logic           go_clear;

    // Only entry states consume events; busy states leave the queue alone.
    assign pop = !fifo_empty &&
                 ((cur_state == ST_ENTA) || (cur_state == ST_ENTB) ||
                  (cur_state == ST_RES));

    assign busy  = (cur_state == ST_LDA) || (cur_state == ST_LDB) ||
                   (cur_state == ST_SETTLE) || (cur_state == ST_LDR) ||
                   (cur_state == ST_CLR);
    assign state = cur_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= ST_ENTA;
        end else begin
            cur_state <= next_state;
        end
    end

    // NOTE: every variable written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        next_state     = cur_state;
        dig_seen_nxt   = dig_seen;
        add_sub_nxt    = add_sub;
        disp_sel_nxt   = disp_sel;
        err_nxt        = err;
        settle_cnt_nxt = settle_cnt;
        go_clear       = 1'b0;

        case (cur_state)
            ST_ENTA: begin
                if (pop) begin
                    if (is_digit) begin
                        dig_seen_nxt = 1'b1;
                    end else if (is_op && dig_seen) begin
                        add_sub_nxt = is_sub;
                        next_state  = ST_LDA;
                    end else if (is_clear) begin
                        go_clear = 1'b1;
                    end
                end
            end

            ST_LDA: begin
                dig_seen_nxt = 1'b0;
                next_state   = ST_ENTB;
            end

            ST_ENTB: begin
                if (pop) begin
                    if (is_digit) begin
                        dig_seen_nxt = 1'b1;
                    end else if (is_op) begin
                        add_sub_nxt = is_sub;
                    end else if (is_equals && dig_seen) begin
                        next_state = ST_LDB;
                    end else if (is_clear) begin
                        go_clear = 1'b1;
                    end
                end
            end

            ST_LDB: begin
                settle_cnt_nxt = '0;
                next_state     = ST_SETTLE;
            end

            // SETTLE lasts SETTLE_CYC cycles, leaving that many idle cycles
            // between the load_b_n and load_r_n pulses.
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    next_state = ST_LDR;
                end else begin
                    settle_cnt_nxt = settle_cnt + SCW'(1);
                end
            end

            // flags are sampled at the edge that ends the load_r_n pulse.
            ST_LDR: begin
                err_nxt      = flags[OVF_BIT];
                disp_sel_nxt = 1'b1;
                next_state   = ST_RES;
            end

            ST_RES: begin
                if (pop) begin
                    if (is_digit) begin
                        disp_sel_nxt = 1'b0;
                        dig_seen_nxt = 1'b1;
                        next_state   = ST_ENTA;
                    end else if (is_clear) begin
                        go_clear = 1'b1;
                    end
                end
            end

            ST_CLR: begin
                next_state = ST_ENTA;
            end
        endcase

        // Clear wipes the operation context at CLR entry, alongside the
        // clear strobes; the queue itself is left intact.
        if (go_clear) begin
            next_state   = ST_CLR;
            add_sub_nxt  = 1'b0;
            disp_sel_nxt = 1'b0;
            err_nxt      = 1'b0;
            dig_seen_nxt = 1'b0;
        end
    end

    // Registered strobes are decoded from next_state, so each pulse lines up
    // exactly with the single cycle spent in its state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_a_n   <= 1'b1;
            load_b_n   <= 1'b1;
            load_r_n   <= 1'b1;
            clear_iu   <= 1'b0;
            clear_au   <= 1'b0;
            add_sub    <= 1'b0;
            disp_sel   <= 1'b0;
            err        <= 1'b0;
            dig_seen   <= 1'b0;
            settle_cnt <= '0;
        end else begin
            load_a_n   <= (next_state != ST_LDA);
            load_b_n   <= (next_state != ST_LDB);
            load_r_n   <= (next_state != ST_LDR);
            clear_iu   <= (next_state == ST_LDA) || (next_state == ST_CLR);
            clear_au   <= (next_state == ST_CLR);
            add_sub    <= add_sub_nxt;
            disp_sel   <= disp_sel_nxt;
            err        <= err_nxt;
            dig_seen   <= dig_seen_nxt;
            settle_cnt <= settle_cnt_nxt;
        end
    end

endmodule
